systolic_act_out: RTL

//  Output stage directly downstream of systolic_2x2: consumes the y0/y1 result pair,

---
 rtl/systolic_act_out.sv | 109 ++++++++++
 1 files changed

// File: rtl/systolic_act_out.sv
// Output stage behind the 2x2 systolic array: per-lane bias add with saturation, activation,
// then a DEPTH-entry FIFO of {z1,z0} pairs toward the next layer under credit-based flow control.
module systolic_act_out #(
  parameter int WIDTH    = 16,
  parameter int FRAC_BIT = 10,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       y_valid,
  output logic                       y_ready,
  input  logic [WIDTH-1:0]           y0,
  input  logic [WIDTH-1:0]           y1,
  input  logic [WIDTH-1:0]           bias0,
  input  logic [WIDTH-1:0]           bias1,
  input  logic [1:0]                 act_sel,
  output logic                       z_valid,
  input  logic                       z_ready,
  output logic [WIDTH-1:0]           z0,
  output logic [WIDTH-1:0]           z1,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);

  // FRAC_BIT only names the Q format; no rescaling depends on it.
  if (FRAC_BIT >= WIDTH) begin : g_frac_out_of_range
  end

  function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] s;
    s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    if (s[WIDTH] != s[WIDTH-1])
      return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] activate(input logic signed [WIDTH-1:0] v,
                                                        input logic [1:0] sel);
    case (sel)
      2'b01:   return v[WIDTH-1] ? '0 : v;
      2'b10:   return v[WIDTH-1] ? (v >>> 3) : v;
      default: return v;
    endcase
  endfunction

  logic                    vld_p1, vld_p2;
  logic signed [WIDTH-1:0] sat0_p1, sat1_p1;
  logic [1:0]              act_p1;
  logic signed [WIDTH-1:0] z0_p2, z1_p2;
  logic [2*WIDTH-1:0]      fifo_mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [FW:0]             credit;
  logic                    accept_p0, push, pop;
  logic [2*WIDTH-1:0]      head;

  // Credit counts FIFO entries plus pairs still in the pipe, so a write can never find the FIFO full.
  assign credit    = {1'b0, fill} + (FW+1)'(vld_p1) + (FW+1)'(vld_p2);
  assign y_ready   = rst_n & (credit < (FW+1)'(DEPTH));
  assign accept_p0 = y_valid & y_ready & ~clr;
  assign push      = vld_p2;
  assign z_valid   = (fill != '0);
  assign pop       = z_valid & z_ready;
  assign head      = fifo_mem[rd_ptr];
  assign z0        = z_valid ? head[WIDTH-1:0]       : '0;
  assign z1        = z_valid ? head[2*WIDTH-1:WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      vld_p1 <= accept_p0;
      vld_p2 <= vld_p1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fill <= fill + FW'(push) - FW'(pop);
    end
  end

  // Stage p0 -> p1: bias add and saturation; act_sel is captured with the pair.
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      sat0_p1 <= sat_add(y0, bias0);
      sat1_p1 <= sat_add(y1, bias1);
      act_p1  <= act_sel;
    end
  end

  // Stage p1 -> p2: activation.
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      z0_p2 <= activate(sat0_p1, act_p1);
      z1_p2 <= activate(sat1_p1, act_p1);
    end
  end

  // Stage p2 -> FIFO: the write pointer is cleared on flush, so stale data is never exposed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {z1_p2, z0_p2};
  end

endmodule
